// File: rtl/sdrc_arb_pkg.sv
// SDRAM application-port arbiter: shared types and helpers.
// Round-robin search used by the arbiter's priority encoder.
package sdrc_arb_pkg;

  localparam int APP_AW_DEF = 26;
  localparam int APP_DW_DEF = 32;
  localparam int LEN_W_DEF  = 9;
  localparam int MAX_REQ    = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } arb_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rr_res_t;

  // Walk from ptr upward with wrap; the lowest offset wins, so scan it last.
  function automatic rr_res_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [1:0]         ptr,
    input logic [2:0]         n
  );
    rr_res_t    r;
    logic [2:0] i;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      i = {1'b0, ptr} + 3'(k);
      if (i >= n) i = i - n;
      if ((3'(k) < n) && req[i[1:0]]) begin
        r.hit = 1'b1;
        r.idx = i[1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sdrc_app_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Returns the first pending requester at or after ptr.
module sdrc_rr_pick
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               hit,
  output logic [1:0]         idx
);

  logic [MAX_REQ-1:0] req_pad;
  rr_res_t            res;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    res = rr_pick(req_pad, ptr, 3'(NUM_REQ));
  end

  assign hit = res.hit;
  assign idx = res.idx;

endmodule

// File: rtl/sdrc_app_arbiter.sv
// Round-robin arbiter sharing the SDRAM app request port.
// Grant is held for a whole burst; beat counter checks length.
module sdrc_app_arbiter
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int APP_AW  = APP_AW_DEF,
  parameter int APP_DW  = APP_DW_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr_n,
  input  logic [NUM_REQ*APP_AW-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic [NUM_REQ*APP_DW-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        req_wr_next,
  output logic [NUM_REQ-1:0]        req_rd_valid,
  output logic [NUM_REQ-1:0]        req_last,
  output logic [APP_DW-1:0]         rd_data,
  output logic                      app_req,
  output logic                      app_req_wr_n,
  output logic [APP_AW-1:0]         app_req_addr,
  output logic [LEN_W-1:0]          app_req_len,
  input  logic                      app_req_ack,
  input  logic                      app_wr_next,
  output logic [APP_DW-1:0]         app_wr_data,
  input  logic                      app_rd_valid,
  input  logic [APP_DW-1:0]         app_rd_data,
  input  logic                      app_last_wr,
  input  logic                      app_last_rd,
  output logic                      len_err
);

  arb_state_e         state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [APP_AW-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               wr_n_q, wr_n_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] zack_q, zack_d;
  logic               len_err_q, len_err_d;

  logic               hit;
  logic [1:0]         gnt;
  logic [LEN_W-1:0]   g_len;
  logic               g_wr_n;
  logic               in_xfer, beat, last_in, cnt_one;
  logic               burst_end, stray;

  sdrc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .hit (hit),
    .idx (gnt)
  );

  always_comb begin
    g_len  = req_len[int'(gnt)*LEN_W +: LEN_W];
    g_wr_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == 2'(i)) g_wr_n = req_wr_n[i];
    end
  end

  always_comb begin
    in_xfer   = (state_q == XFER);
    beat      = in_xfer & (wr_n_q ? app_rd_valid : app_wr_next);
    last_in   = wr_n_q ? app_last_rd : app_last_wr;
    cnt_one   = (beat_cnt_q == LEN_W'(1));
    burst_end = beat & (cnt_one | last_in);
    stray     = ~in_xfer & (app_wr_next | app_rd_valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit && (g_len != '0)) state_d = REQ;
      REQ:     if (app_req_ack)          state_d = XFER;
      XFER:    if (burst_end)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_n_d     = wr_n_q;
    beat_cnt_d = beat_cnt_q;
    zack_d     = '0;
    len_err_d  = len_err_q | stray | (beat & (last_in != cnt_one));
    if ((state_q == IDLE) && hit) begin
      owner_d    = gnt;
      addr_d     = req_addr[int'(gnt)*APP_AW +: APP_AW];
      len_d      = g_len;
      wr_n_d     = g_wr_n;
      beat_cnt_d = g_len;
      rr_ptr_d   = (gnt == 2'(NUM_REQ - 1)) ? 2'd0 : gnt + 2'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        zack_d[i] = (gnt == 2'(i)) && (g_len == '0);
      end
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_n_q     <= 1'b0;
      beat_cnt_q <= '0;
      zack_q     <= '0;
      len_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_n_q     <= wr_n_d;
      beat_cnt_q <= beat_cnt_d;
      zack_q     <= zack_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    req_ack      = '0;
    req_wr_next  = '0;
    req_rd_valid = '0;
    req_last     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        req_ack[i]      = zack_q[i] | ((state_q == REQ) & app_req_ack);
        req_wr_next[i]  = in_xfer & ~wr_n_q & app_wr_next;
        req_rd_valid[i] = in_xfer & wr_n_q & app_rd_valid;
        req_last[i]     = burst_end;
      end else begin
        req_ack[i]      = zack_q[i];
      end
    end
    app_wr_data = req_wr_data[int'(owner_q)*APP_DW +: APP_DW];
  end

  assign rd_data      = app_rd_data;
  assign app_req      = (state_q == REQ);
  assign app_req_wr_n = wr_n_q;
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Directed bench for sdrc_app_arbiter.
// Hand-computed expectations, immediate assertions.
module tb_sdrc_app_arbiter;

  localparam int N  = 2;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 9;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_wr_n;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ack;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]    req_wr_next;
  logic [N-1:0]    req_rd_valid;
  logic [N-1:0]    req_last;
  logic [DW-1:0]   rd_data;
  logic            app_req;
  logic            app_req_wr_n;
  logic [AW-1:0]   app_req_addr;
  logic [LW-1:0]   app_req_len;
  logic            app_req_ack;
  logic            app_wr_next;
  logic [DW-1:0]   app_wr_data;
  logic            app_rd_valid;
  logic [DW-1:0]   app_rd_data;
  logic            app_last_wr;
  logic            app_last_rd;
  logic            len_err;

  int total = 0;
  int bad   = 0;

  sdrc_app_arbiter #(
    .NUM_REQ(N), .APP_AW(AW), .APP_DW(DW), .LEN_W(LW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_wr_n     (req_wr_n),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_ack      (req_ack),
    .req_wr_data  (req_wr_data),
    .req_wr_next  (req_wr_next),
    .req_rd_valid (req_rd_valid),
    .req_last     (req_last),
    .rd_data      (rd_data),
    .app_req      (app_req),
    .app_req_wr_n (app_req_wr_n),
    .app_req_addr (app_req_addr),
    .app_req_len  (app_req_len),
    .app_req_ack  (app_req_ack),
    .app_wr_next  (app_wr_next),
    .app_wr_data  (app_wr_data),
    .app_rd_valid (app_rd_valid),
    .app_rd_data  (app_rd_data),
    .app_last_wr  (app_last_wr),
    .app_last_rd  (app_last_rd),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int o, input logic wr_n,
                         input logic [AW-1:0] a,
                         input logic [LW-1:0] l);
    req_valid[o]          = 1'b1;
    req_wr_n[o]           = wr_n;
    req_addr[o*AW +: AW]  = a;
    req_len[o*LW +: LW]   = l;
  endtask

  task automatic grant(input int o, input logic [AW-1:0] a,
                       input logic [LW-1:0] l, input logic wr_n,
                       input int exp_wait);
    int k;
    logic [N-1:0] oh;
    oh = N'(1 << o);
    k  = 0;
    while (app_req !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("app_req_seen", app_req, 1);
    chk("grant_wait", k, exp_wait);
    chk("app_req_addr", app_req_addr, a);
    chk("app_req_len", app_req_len, l);
    chk("app_req_wr_n", app_req_wr_n, wr_n);
    step();
    chk("app_req_hold", app_req, 1);
    chk("req_ack_wait", req_ack, 0);
    app_req_ack = 1'b1;
    #1;
    chk("req_ack", req_ack, oh);
    step();
    app_req_ack  = 1'b0;
    req_valid[o] = 1'b0;
    #1;
    chk("app_req_drop", app_req, 0);
  endtask

  task automatic wbeats(input int o, input int n, input int last_at,
                        input int end_at, input logic [DW-1:0] base);
    logic [N-1:0] oh;
    oh = N'(1 << o);
    for (int b = 1; b <= n; b++) begin
      req_wr_data[o*DW +: DW] = base + DW'(b);
      app_wr_next = 1'b1;
      app_last_wr = (b == last_at);
      #1;
      chk("req_wr_next", req_wr_next, oh);
      chk("app_wr_data", app_wr_data, base + DW'(b));
      chk("req_last_w", req_last, (b == end_at) ? oh : '0);
      step();
    end
    app_wr_next = 1'b0;
    app_last_wr = 1'b0;
  endtask

  task automatic rbeats(input int o, input int n, input int last_at,
                        input int end_at, input logic [DW-1:0] base);
    logic [N-1:0] oh;
    oh = N'(1 << o);
    for (int b = 1; b <= n; b++) begin
      app_rd_data  = base + DW'(b);
      app_rd_valid = 1'b1;
      app_last_rd  = (b == last_at);
      #1;
      chk("req_rd_valid", req_rd_valid, oh);
      chk("rd_data", rd_data, base + DW'(b));
      chk("req_wr_next_r", req_wr_next, 0);
      chk("req_last_r", req_last, (b == end_at) ? oh : '0);
      step();
    end
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_wr_n     = '0;
    req_addr     = '0;
    req_len      = '0;
    req_wr_data  = '0;
    app_req_ack  = 1'b0;
    app_wr_next  = 1'b0;
    app_rd_valid = 1'b0;
    app_rd_data  = '0;
    app_last_wr  = 1'b0;
    app_last_rd  = 1'b0;
    step();
    step();
    chk("rst_app_req", app_req, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_wr_next", req_wr_next, 0);
    chk("rst_rd_valid", req_rd_valid, 0);
    chk("rst_last", req_last, 0);
    chk("rst_len_err", len_err, 0);
    reset_n = 1'b1;
    step();

    // single write len=4 on req0
    set_req(0, 1'b0, 26'h0123, 9'd4);
    grant(0, 26'h0123, 9'd4, 1'b0, 1);
    wbeats(0, 4, 4, 4, 32'hD000_0000);
    chk("t1_len_err", len_err, 0);
    chk("t1_idle", app_req, 0);

    // both valid from rr_ptr=0, then fairness with both valid again
    do_reset();
    set_req(0, 1'b0, 26'h0A00, 9'd2);
    set_req(1, 1'b0, 26'h0B00, 9'd2);
    grant(0, 26'h0A00, 9'd2, 1'b0, 1);
    wbeats(0, 2, 2, 2, 32'hA000_0000);
    set_req(0, 1'b0, 26'h0C00, 9'd2);
    grant(1, 26'h0B00, 9'd2, 1'b0, 1);
    wbeats(1, 2, 2, 2, 32'hB000_0000);
    grant(0, 26'h0C00, 9'd2, 1'b0, 1);
    wbeats(0, 2, 2, 2, 32'hC000_0000);
    chk("t2_len_err", len_err, 0);

    // read len=8 to req1 (rr_ptr=1 now)
    set_req(1, 1'b1, 26'h1F00, 9'd8);
    grant(1, 26'h1F00, 9'd8, 1'b1, 1);
    rbeats(1, 8, 8, 8, 32'h5500_0000);
    chk("t3_len_err", len_err, 0);

    // early app_last_wr on beat 3 of a len=4 write
    set_req(0, 1'b0, 26'h0200, 9'd4);
    grant(0, 26'h0200, 9'd4, 1'b0, 1);
    wbeats(0, 3, 3, 3, 32'hE000_0000);
    chk("t4_len_err", len_err, 1);
    chk("t4_idle", app_req, 0);
    step();
    step();
    chk("t4_len_err_sticky", len_err, 1);
    chk("t4_idle2", app_req, 0);

    // zero-length request on req0, req1 pending too
    do_reset();
    chk("t5_len_err_clr", len_err, 0);
    set_req(0, 1'b0, 26'h0300, 9'd0);
    set_req(1, 1'b0, 26'h0400, 9'd2);
    #1;
    chk("t5_ack_early", req_ack, 0);
    step();
    chk("t5_zack", req_ack, 2'b01);
    chk("t5_no_app_req", app_req, 0);
    req_valid[0] = 1'b0;
    grant(1, 26'h0400, 9'd2, 1'b0, 1);
    wbeats(1, 2, 2, 2, 32'h4400_0000);
    chk("t5_len_err", len_err, 0);

    // reset in the middle of a burst (rr_ptr=0 here)
    set_req(0, 1'b0, 26'h0500, 9'd4);
    grant(0, 26'h0500, 9'd4, 1'b0, 1);
    wbeats(0, 2, 0, 0, 32'h6600_0000);
    app_wr_next = 1'b1;
    #1;
    chk("t6_pre_wr_next", req_wr_next, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("t6_wr_next", req_wr_next, 0);
    chk("t6_app_req", app_req, 0);
    chk("t6_last", req_last, 0);
    chk("t6_len_err", len_err, 0);
    app_wr_next = 1'b0;
    step();
    reset_n = 1'b1;
    set_req(0, 1'b0, 26'h0600, 9'd1);
    set_req(1, 1'b0, 26'h0700, 9'd1);
    grant(0, 26'h0600, 9'd1, 1'b0, 1);
    wbeats(0, 1, 1, 1, 32'h7700_0000);
    chk("t6_post_len_err", len_err, 0);
    grant(1, 26'h0700, 9'd1, 1'b0, 1);
    wbeats(1, 1, 1, 1, 32'h8800_0000);
    chk("t6_final_len_err", len_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
